// File: rtl/kdf_key_checker.sv
// -----------------------------------------------------------------------------
// kdf_key_checker
//
// Checks a candidate password against a stored reference key by running it
// through an external KDF core and comparing the derived key. Consecutive
// mismatches are counted; when MAX_ATTEMPTS is reached the block locks until
// reset.
//
// Handshake: start is a one-cycle request, accepted only in IDLE (busy=0,
// locked=0); a start seen in any other state is dropped, never queued. Every
// accepted request produces exactly one done pulse, and match/error are valid
// with done and held until the next accepted start. A reset aborts the request
// in flight without a done pulse.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   start               one-cycle request to check user_password
//   user_password, salt, count   request operands (count==0 is an error)
//   ref_key             stored reference key, stable while busy
//   kdf_rst             active-high reset to the KDF core (low only in RUN/COMPARE)
//   kdf_password, kdf_salt, kdf_count   operands latched for the KDF core
//   kdf_end_signal, kdf_key             KDF completion level and derived key
//   busy, done, match, error, locked    status / result
//   attempts_left       MAX_ATTEMPTS minus consecutive mismatches
//   state_dbg           current FSM state encoding
// -----------------------------------------------------------------------------
module kdf_key_checker #(
  parameter int N             = 128,
  parameter int SALT_WIDTH    = 64,
  parameter int COUNT_WIDTH   = 32,
  parameter int PSW_WIDTH     = 80,
  parameter int MAX_ATTEMPTS  = 3,
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PSW_WIDTH-1:0]   user_password,
  input  logic [SALT_WIDTH-1:0]  salt,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic [N-1:0]           ref_key,
  output logic                   kdf_rst,
  output logic [PSW_WIDTH-1:0]   kdf_password,
  output logic [SALT_WIDTH-1:0]  kdf_salt,
  output logic [COUNT_WIDTH-1:0] kdf_count,
  input  logic                   kdf_end_signal,
  input  logic [N-1:0]           kdf_key,
  output logic                   busy,
  output logic                   done,
  output logic                   match,
  output logic                   error,
  output logic                   locked,
  output logic [3:0]             attempts_left,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_RUN     = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4,
    S_LOCKED  = 3'd5
  } state_t;

  localparam logic [3:0]               MAX_A  = 4'(MAX_ATTEMPTS);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state, state_nx;
  logic                     launch_second;   // second LAUNCH cycle
  logic [TIMEOUT_WIDTH-1:0] wd, wd_inc;      // RUN cycle index, 0 in first RUN cycle
  logic [N-1:0]             key_q;
  logic [3:0]               fail_cnt, fail_nx;
  logic                     match_q, error_q;
  logic                     accept, zero_req, capture, timeout;

  assign wd_inc = wd + WD_ONE;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    zero_req = 1'b0;
    capture  = 1'b0;
    timeout  = 1'b0;
    fail_nx  = fail_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            accept   = 1'b1;
            state_nx = S_LAUNCH;
          end else begin
            zero_req = 1'b1;
            state_nx = S_DONE;
          end
        end
      end
      S_LAUNCH: begin
        if (launch_second) state_nx = S_RUN;
      end
      S_RUN: begin
        // The KDF may still show a stale end level right after its reset is
        // released, so the first RUN cycle (wd==0) never captures.
        if (wd != '0 && kdf_end_signal) begin
          capture  = 1'b1;
          state_nx = S_COMPARE;
        end else if (wd_inc == '1) begin
          timeout  = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_COMPARE: state_nx = S_DONE;
      S_DONE: begin
        // Errors (zero count, timeout) leave the mismatch history untouched.
        if (match_q) begin
          fail_nx = '0;
        end else if (!error_q && fail_cnt != MAX_A) begin
          fail_nx = fail_cnt + 4'd1;
        end
        state_nx = (fail_nx == MAX_A) ? S_LOCKED : S_IDLE;
      end
      S_LOCKED: state_nx = S_LOCKED;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      launch_second <= 1'b0;
      wd            <= '0;
      key_q         <= '0;
      fail_cnt      <= '0;
      match_q       <= 1'b0;
      error_q       <= 1'b0;
      kdf_password  <= '0;
      kdf_salt      <= '0;
      kdf_count     <= '0;
    end else begin
      state         <= state_nx;
      fail_cnt      <= fail_nx;
      launch_second <= (state == S_LAUNCH) && !launch_second;
      wd            <= (state == S_RUN) ? wd_inc : '0;
      if (accept) begin
        kdf_password <= user_password;
        kdf_salt     <= salt;
        kdf_count    <= count;
        match_q      <= 1'b0;
        error_q      <= 1'b0;
      end
      if (zero_req || timeout) begin
        match_q <= 1'b0;
        error_q <= 1'b1;
      end
      if (capture) key_q <= kdf_key;
      if (state == S_COMPARE) match_q <= (key_q == ref_key);
    end
  end

  // KDF core is held in reset everywhere except while it is working.
  assign kdf_rst       = !(state == S_RUN || state == S_COMPARE);
  assign busy          = !(state == S_IDLE || state == S_LOCKED);
  assign done          = (state == S_DONE);
  assign locked        = (state == S_LOCKED);
  assign match         = match_q;
  assign error         = error_q;
  assign attempts_left = MAX_A - fail_cnt;
  assign state_dbg     = state;

endmodule

// File: tb/tb_kdf_key_checker.sv
// -----------------------------------------------------------------------------
// tb_kdf_key_checker
//
// Bench for kdf_key_checker with TIMEOUT_WIDTH=4 (15-cycle RUN watchdog) and
// MAX_ATTEMPTS=3. A small KDF model releases kdf_end_signal a programmable
// number of RUN cycles after kdf_rst falls. Each request pushes its expected
// {done cycle, match, error, attempts_left afterwards} to exp_q; a monitor pops
// and compares on every done pulse, flagging any done with nothing expected.
// -----------------------------------------------------------------------------
module tb_kdf_key_checker;

  localparam int N       = 128;
  localparam int SALT_W  = 64;
  localparam int CNT_W   = 32;
  localparam int PSW_W   = 80;
  localparam int MAX_ATT = 3;
  localparam int TO_W    = 4;
  localparam int EW      = 22;  // {cycle[15:0], match, error, attempts[3:0]}

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [PSW_W-1:0]  user_password = '0;
  logic [SALT_W-1:0] salt = '0;
  logic [CNT_W-1:0]  count = '0;
  logic [N-1:0]      ref_key = '0;
  logic              kdf_rst;
  logic [PSW_W-1:0]  kdf_password;
  logic [SALT_W-1:0] kdf_salt;
  logic [CNT_W-1:0]  kdf_count;
  logic              kdf_end_signal = 1'b0;
  logic [N-1:0]      kdf_key = '0;
  logic              busy, done, match, error, locked;
  logic [3:0]        attempts_left;
  logic [2:0]        state_dbg;

  kdf_key_checker #(
    .N(N), .SALT_WIDTH(SALT_W), .COUNT_WIDTH(CNT_W), .PSW_WIDTH(PSW_W),
    .MAX_ATTEMPTS(MAX_ATT), .TIMEOUT_WIDTH(TO_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .user_password(user_password),
    .salt(salt), .count(count), .ref_key(ref_key), .kdf_rst(kdf_rst),
    .kdf_password(kdf_password), .kdf_salt(kdf_salt), .kdf_count(kdf_count),
    .kdf_end_signal(kdf_end_signal), .kdf_key(kdf_key), .busy(busy),
    .done(done), .match(match), .error(error), .locked(locked),
    .attempts_left(attempts_left), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- KDF model ----------------
  int           run_idx = 0;
  int           model_delay = 0;   // 0 = never finish
  logic [N-1:0] model_key = '0;
  logic [N-1:0] model_bad_key = '0; // driven in RUN cycle 1 only

  always @(negedge clk) begin
    if (kdf_rst) run_idx = 0;
    else         run_idx = run_idx + 1;
    kdf_end_signal = (model_delay != 0) && (run_idx >= model_delay);
    kdf_key        = (run_idx <= 1) ? model_bad_key : model_key;
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  logic          att_pending = 1'b0;
  logic [3:0]    att_exp = '0;

  always @(negedge clk) begin
    if (att_pending) begin
      att_pending = 1'b0;
      n_cmp++;
      if (attempts_left !== att_exp) begin
        n_err++;
        $display("FAIL attempts_after_done: got %0d want %0d", attempts_left, att_exp);
      end
    end
    if (rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: done at cycle %0d, none expected", cyc);
      end else begin
        exp_e = exp_q.pop_front();
        n_cmp++;
        if (cyc[15:0] !== exp_e[21:6]) begin
          n_err++;
          $display("FAIL done_cycle: got %0d want %0d", cyc[15:0], exp_e[21:6]);
        end
        n_cmp++;
        if ({match, error} !== exp_e[5:4]) begin
          n_err++;
          $display("FAIL result: got match=%b error=%b want match=%b error=%b",
                   match, error, exp_e[5], exp_e[4]);
        end
        att_exp     = exp_e[3:0];
        att_pending = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [SALT_W-1:0] last_salt;

  function automatic logic [PSW_W-1:0] rand_pw();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[PSW_W-1:0];
  endfunction

  task automatic issue(input logic [PSW_W-1:0] pw, input logic [CNT_W-1:0] cnt,
                       output int t);
    @(posedge clk); #1;
    user_password = pw;
    last_salt     = {$urandom(), $urandom()};
    salt          = last_salt;
    count         = cnt;
    start         = 1'b1;
    t             = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);  // let the monitor check attempts_left
  endtask

  task automatic push_exp(input int dcyc, input logic m, input logic e, input int att);
    exp_q.push_back({16'(dcyc), m, e, 4'(att)});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({kdf_rst, busy, done, match, error, locked, attempts_left} !== 10'b1_00000_0011) begin
      n_err++;
      $display("FAIL reset_status: got %b want 1000000011",
               {kdf_rst, busy, done, match, error, locked, attempts_left});
    end
    n_cmp++;
    if ({kdf_password, kdf_salt, kdf_count} !== '0) begin
      n_err++;
      $display("FAIL reset_kdf_data: got %h want 0", {kdf_password, kdf_salt, kdf_count});
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_match();
    int t; bit ok;
    logic [PSW_W-1:0] pw;
    ref_key       = {$urandom(), $urandom(), $urandom(), $urandom()};
    model_key     = ref_key;
    model_bad_key = ref_key;
    model_delay   = 10;
    pw = rand_pw();
    issue(pw, 32'd4, t);
    push_exp(t + 14, 1'b1, 1'b0, 3);
    repeat (3) @(posedge clk); #1;   // RUN cycle 2
    user_password = ~pw;
    salt          = ~last_salt;
    count         = 32'd77;
    @(posedge clk); #1;
    n_cmp++;
    if ({kdf_password, kdf_salt, kdf_count} !== {pw, last_salt, 32'd4}) begin
      n_err++;
      $display("FAIL latched_operands: got %h want %h",
               {kdf_password, kdf_salt, kdf_count}, {pw, last_salt, 32'd4});
    end
    n_cmp++;
    if ({kdf_rst, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL run_status: got kdf_rst=%b busy=%b want 0 1", kdf_rst, busy);
    end
    issue(rand_pw(), 32'd0, t);      // start while busy must be dropped
    wait_done(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL match_done_timeout: got no done want done"); end
    n_cmp++;
    if ({busy, kdf_rst} !== 2'b01) begin
      n_err++;
      $display("FAIL idle_after_match: got busy=%b kdf_rst=%b want 0 1", busy, kdf_rst);
    end
  endtask

  task automatic test_mismatch_then_match();
    int t; bit ok;
    model_key = ~ref_key; model_bad_key = ~ref_key; model_delay = 3;
    issue(rand_pw(), 32'd3, t);
    push_exp(t + 7, 1'b0, 1'b0, 2);
    wait_done(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL mismatch_done_timeout: got no done want done"); end
    model_key = ref_key; model_bad_key = ref_key; model_delay = 5;
    issue(rand_pw(), 32'($urandom_range(1, 1000)), t);
    push_exp(t + 9, 1'b1, 1'b0, 3);
    wait_done(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rematch_done_timeout: got no done want done"); end
  endtask

  task automatic test_zero_count();
    int t; bit ok;
    model_key = ~ref_key; model_bad_key = ~ref_key; model_delay = 2;
    issue(rand_pw(), 32'd9, t);
    push_exp(t + 6, 1'b0, 1'b0, 2);
    wait_done(40, ok);
    issue(rand_pw(), 32'd0, t);
    push_exp(t + 1, 1'b0, 1'b1, 2);
    n_cmp++;
    if ({kdf_rst, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL zero_count_kdf_rst: got kdf_rst=%b busy=%b want 1 1", kdf_rst, busy);
    end
    wait_done(10, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL zero_count_done_timeout: got no done want done"); end
  endtask

  task automatic test_timeout();
    int t; bit ok;
    model_delay = 0;
    issue(rand_pw(), 32'd5, t);
    push_exp(t + 18, 1'b0, 1'b1, 2);   // 15 RUN cycles starting at t+3
    wait_done(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL timeout_done_timeout: got no done want done"); end
    n_cmp++;
    if (kdf_rst !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_kdf_rst: got %b want 1", kdf_rst);
    end
  endtask

  task automatic test_early_end();
    int t; bit ok;
    model_key = ref_key; model_bad_key = ~ref_key; model_delay = 1;
    issue(rand_pw(), 32'd2, t);
    push_exp(t + 6, 1'b1, 1'b0, 3);    // capture in RUN cycle 2 (t+4)
    wait_done(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL early_end_done_timeout: got no done want done"); end
  endtask

  task automatic test_reset_mid_run();
    int t; bit ok;
    model_key = ~ref_key; model_bad_key = ~ref_key; model_delay = 2;
    issue(rand_pw(), 32'd6, t);
    push_exp(t + 6, 1'b0, 1'b0, 2);
    wait_done(40, ok);
    model_delay = 0;
    issue(rand_pw(), 32'd6, t);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if ({kdf_rst, busy, done, match, error, locked, attempts_left} !== 10'b1_00000_0011) begin
      n_err++;
      $display("FAIL async_reset_status: got %b want 1000000011",
               {kdf_rst, busy, done, match, error, locked, attempts_left});
    end
    n_cmp++;
    if ({kdf_password, kdf_salt, kdf_count} !== '0) begin
      n_err++;
      $display("FAIL async_reset_kdf_data: got %h want 0", {kdf_password, kdf_salt, kdf_count});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_key = ref_key; model_bad_key = ref_key; model_delay = 6;
    issue(rand_pw(), 32'd4, t);
    push_exp(t + 10, 1'b1, 1'b0, 3);
    wait_done(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL post_reset_done_timeout: got no done want done"); end
  endtask

  task automatic test_lockout();
    int t; bit ok; int released;
    model_key = ~ref_key; model_bad_key = ~ref_key;
    for (int i = 0; i < MAX_ATT; i++) begin
      model_delay = 2 + i;
      issue(rand_pw(), 32'($urandom_range(1, 50)), t);
      push_exp(t + 6 + i, 1'b0, 1'b0, MAX_ATT - 1 - i);
      wait_done(40, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL lockout_done_timeout: attempt %0d got no done", i); end
    end
    n_cmp++;
    if ({locked, busy, kdf_rst} !== 3'b101) begin
      n_err++;
      $display("FAIL locked_status: got locked=%b busy=%b kdf_rst=%b want 1 0 1",
               locked, busy, kdf_rst);
    end
    model_key = ref_key; model_delay = 2;
    issue(rand_pw(), 32'd4, t);
    released = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (kdf_rst !== 1'b1) released++;
    end
    n_cmp++;
    if (released != 0 || locked !== 1'b1) begin
      n_err++;
      $display("FAIL locked_ignores_start: got %0d released cycles locked=%b want 0 1",
               released, locked);
    end
    @(posedge clk); #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({locked, attempts_left} !== 5'b0_0011) begin
      n_err++;
      $display("FAIL unlock_by_reset: got locked=%b attempts=%0d want 0 3", locked, attempts_left);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch_then_match();
    test_zero_count();
    test_timeout();
    test_early_end();
    test_reset_mid_run();
    test_lockout();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_results: got %0d outstanding want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kdf_key_checker.md
KDF_KEY_CHECKER -- requirements
Module: kdf_key_checker

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N, 128, derived-key width.
- SALT_WIDTH, 64, salt width.
- COUNT_WIDTH, 32, iteration-count width.
- PSW_WIDTH, 80, password width.
- MAX_ATTEMPTS, 3, consecutive mismatches before lockout (1..15).
- TIMEOUT_WIDTH, 24, width of RUN watchdog; timeout = 2^TIMEOUT_WIDTH-1 cycles.

REQ-002 Ports (name direction width meaning), one per line:
- clk input 1 single clock, all state on rising edge.
- rst input 1 reset; asynchronous, active-low.
- start input 1 one-cycle request to check a password.
- user_password input PSW_WIDTH candidate password.
- salt input SALT_WIDTH salt.
- count input COUNT_WIDTH iteration count.
- ref_key input N stored reference key, stable while busy.
- kdf_rst output 1 active-high reset to the KDF core.
- kdf_password output PSW_WIDTH latched password to the KDF.
- kdf_salt output SALT_WIDTH latched salt to the KDF.
- kdf_count output COUNT_WIDTH latched count to the KDF.
- kdf_end_signal input 1 KDF iteration-complete level.
- kdf_key input N KDF derived key.
- busy output 1 high in any state except IDLE and LOCKED.
- done output 1 one-cycle result strobe.
- match output 1 result: derived key equals ref_key; valid with done, held until next start.
- error output 1 result: zero count or timeout; valid with done, held until next start.
- locked output 1 lockout active.
- attempts_left output 4 MAX_ATTEMPTS minus consecutive mismatches.

Function
REQ-003 FSM states IDLE, LAUNCH, RUN, COMPARE, DONE, LOCKED; one state per cycle except LAUNCH (2 cycles) and RUN.
REQ-004 IDLE: start=1 with count!=0 -> latch user_password/salt/count into kdf_* registers, clear match/error, go LAUNCH.
REQ-005 IDLE: start=1 with count==0 -> no KDF launch; go DONE with error=1, match=0; attempts unchanged.
REQ-006 LAUNCH: kdf_rst=1 for exactly 2 cycles, then go RUN; kdf_rst=0 in RUN, COMPARE; kdf_rst=1 in all other states.
REQ-007 RUN: kdf_end_signal ignored in first RUN cycle; from second RUN cycle, kdf_end_signal=1 captures kdf_key into an N-bit register and moves to COMPARE.
REQ-008 RUN watchdog counts RUN cycles from 0; reaching all-ones -> DONE with error=1, match=0; attempts unchanged.
REQ-009 COMPARE: match := (captured key == ref_key) full N-bit compare; go DONE.
REQ-010 DONE: done=1 for one cycle; on match, fail counter cleared; on mismatch without error, fail counter +1; next state LOCKED if fail counter reaches MAX_ATTEMPTS, else IDLE.
REQ-011 Latency: start at cycle T, end_signal seen in RUN at cycle E -> done at E+2; count==0 -> done at T+1.
REQ-012 start outside IDLE ignored (no queueing); kdf_* inputs stable from LAUNCH to DONE.
REQ-013 LOCKED: locked=1, start ignored, kdf_rst=1; exit only by reset.
REQ-014 attempts_left = MAX_ATTEMPTS - fail counter, combinational from the registered counter; fail counter saturates at MAX_ATTEMPTS.
REQ-015 done, match and error do not depend combinationally on kdf_end_signal or kdf_key.

Reset
REQ-016 rst=0 asynchronously forces IDLE, kdf_rst=1, kdf_* data=0, captured key=0, watchdog=0, fail counter=0, busy=0, done=0, match=0, error=0, locked=0, attempts_left=MAX_ATTEMPTS.
REQ-017 Reset in any state, including RUN and LOCKED, aborts the operation with no done pulse; the first start is accepted one cycle after rst deasserts.

Verification
REQ-018 Correct password, count=4, KDF model asserts end_signal 10 cycles into RUN with kdf_key=ref_key -> done at E+2, match=1, error=0, attempts_left=3.
REQ-019 Three wrong passwords in succession, MAX_ATTEMPTS=3 -> attempts_left 2,1,0; after the third done, locked=1, busy=0; a further start gives no kdf_rst release.
REQ-020 start with count=0 -> done next cycle, error=1, match=0, kdf_rst stays 1.
REQ-021 TIMEOUT_WIDTH=4, end_signal held 0 -> done 15 RUN cycles in, error=1, attempts unchanged.
REQ-022 end_signal already 1 in first RUN cycle -> ignored; capture occurs in second RUN cycle.
REQ-023 rst pulse low mid-RUN -> all outputs return to reset values asynchronously; no done; a new start completes normally.
